serial_frame_tx: RTL and testbench

//   Serial frame transmitter: accepts a parallel word via valid/ready and emits it
//   on a single-bit line as start bit, data LSB-first, optional even parity, stop bit.

---
 rtl/serial_frame_tx_if.sv | 23 ++
 rtl/serial_frame_tx.sv | 134 +++++++++++++
 tb/tb_serial_frame_tx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-line bundle for serial_frame_tx.
// The master side supplies words and the slave side (the transmitter) drives the serial outputs.
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              out;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, out, busy, done, dbg_state
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, out, busy, done, dbg_state
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB-first, optional even parity, stop bit.
// Idle line is high; every serial bit is held for BIT_CYCLES clocks.
module serial_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 1
) (
  input  logic               clk,
  input  logic               reset,
  serial_frame_tx_if.slave   bus
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CYC_MAX  = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_W - 1);
  localparam logic          STOP_ONE = (BIT_CYCLES == 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [CW-1:0]     cyc_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic              out_q;
  logic              done_q;

  logic              cyc_last;
  logic [CW-1:0]     cyc_inc;
  logic [DATA_W-1:0] shreg_nxt;

  assign cyc_last  = (cyc_cnt == CYC_MAX);
  assign cyc_inc   = cyc_cnt + CW'(1);
  assign shreg_nxt = shreg >> 1;

  // Handshake: a word transfers on a rising edge where tx_valid and tx_ready are both 1;
  // tx_ready is a pure function of the state (IDLE) and is held low while reset is asserted.
  assign bus.tx_ready  = (state == IDLE) && !reset;
  assign bus.busy      = (state != IDLE);
  assign bus.out       = out_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state;

  // out_q and done_q are computed from the state being entered, so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      out_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          out_q <= 1'b1;
          if (bus.tx_valid) begin
            shreg   <= bus.tx_data;
            par     <= ^bus.tx_data;
            cyc_cnt <= '0;
            state   <= START;
            out_q   <= 1'b0;
          end
        end
        START: begin
          if (cyc_last) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            out_q   <= shreg[0];
          end else begin
            cyc_cnt <= cyc_inc;
          end
        end
        DATA: begin
          if (cyc_last) begin
            cyc_cnt <= '0;
            if (bit_cnt == BIT_MAX) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                out_q <= par;
              end else begin
                state  <= STOP;
                out_q  <= 1'b1;
                done_q <= STOP_ONE;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shreg   <= shreg_nxt;
              out_q   <= shreg_nxt[0];
            end
          end else begin
            cyc_cnt <= cyc_inc;
          end
        end
        PARITY: begin
          if (cyc_last) begin
            cyc_cnt <= '0;
            state   <= STOP;
            out_q   <= 1'b1;
            done_q  <= STOP_ONE;
          end else begin
            cyc_cnt <= cyc_inc;
          end
        end
        STOP: begin
          out_q <= 1'b1;
          if (cyc_last) begin
            cyc_cnt <= '0;
            state   <= IDLE;
          end else begin
            cyc_cnt <= cyc_inc;
            done_q  <= (cyc_inc == CYC_MAX);
          end
        end
        default: begin
          cyc_cnt <= '0;
          state   <= IDLE;
          out_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx in three configurations sharing one clock and reset:
// A (8,1,parity), B (8,4,parity), C (8,1,no parity).
module tb_serial_frame_tx;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  serial_frame_tx_if #(.DATA_W(8)) ifa ();
  serial_frame_tx_if #(.DATA_W(8)) ifb ();
  serial_frame_tx_if #(.DATA_W(8)) ifc ();

  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4), .PARITY_EN(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(0)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Runs one 11-cycle frame on A, starting with the accepting edge.
  task automatic run_frame_a(input string tag, input logic [10:0] exp,
                             input bit drop_valid, input bit change, input logic [7:0] new_data);
    for (int i = 0; i < 11; i++) begin
      tick();
      chk({tag, "_out"}, 32'(ifa.out), 32'(exp[i]));
      chk({tag, "_done"}, 32'(ifa.done), 32'(i == 10));
      chk({tag, "_busy"}, 32'(ifa.busy), 32'd1);
      if (i == 0 && drop_valid) ifa.tx_valid = 1'b0;
      if (i == 4 && change) ifa.tx_data = new_data;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] exp11;
    logic [9:0]  exp10;
    int          done_cnt;

    reset = 1'b1;
    ifa.tx_valid = 1'b0; ifa.tx_data = 8'h00;
    ifb.tx_valid = 1'b0; ifb.tx_data = 8'h00;
    ifc.tx_valid = 1'b0; ifc.tx_data = 8'h00;

    // Reset held: line idle, not ready
    tick(); tick();
    chk("rst_out",   32'(ifa.out),      32'd1);
    chk("rst_busy",  32'(ifa.busy),     32'd0);
    chk("rst_done",  32'(ifa.done),     32'd0);
    chk("rst_ready", 32'(ifa.tx_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_ready", 32'(ifa.tx_ready), 32'd1);
    tick();
    chk("rel_ready2", 32'(ifa.tx_ready), 32'd1);
    chk("rel_out",    32'(ifa.out),      32'd1);

    // 0xA5 with even parity 0
    ifa.tx_data = 8'hA5; ifa.tx_valid = 1'b1;
    run_frame_a("a5", 11'b10101001010, 1'b1, 1'b0, 8'h00);
    tick();
    chk("a5_idle_out",   32'(ifa.out),      32'd1);
    chk("a5_idle_busy",  32'(ifa.busy),     32'd0);
    chk("a5_idle_done",  32'(ifa.done),     32'd0);
    chk("a5_idle_ready", 32'(ifa.tx_ready), 32'd1);

    // 0x01 on B: each bit held 4 cycles, parity 1, 44-cycle frame
    exp11 = 11'b11000000010;
    ifb.tx_data = 8'h01; ifb.tx_valid = 1'b1;
    for (int i = 0; i < 44; i++) begin
      tick();
      if (i == 0) ifb.tx_valid = 1'b0;
      chk("b_out",  32'(ifb.out),  32'(exp11[i / 4]));
      chk("b_done", 32'(ifb.done), 32'(i == 43));
      chk("b_busy", 32'(ifb.busy), 32'd1);
    end
    tick();
    chk("b_idle_busy",  32'(ifb.busy),     32'd0);
    chk("b_idle_ready", 32'(ifb.tx_ready), 32'd1);
    chk("b_idle_out",   32'(ifb.out),      32'd1);

    // Back-to-back with tx_data changed mid-frame: 0x3C then 0xC3
    ifa.tx_data = 8'h3C; ifa.tx_valid = 1'b1;
    run_frame_a("b2b1", 11'b10001111000, 1'b0, 1'b1, 8'hC3);
    tick();
    chk("b2b_gap_out",   32'(ifa.out),      32'd1);
    chk("b2b_gap_ready", 32'(ifa.tx_ready), 32'd1);
    chk("b2b_gap_busy",  32'(ifa.busy),     32'd0);
    run_frame_a("b2b2", 11'b10110000110, 1'b1, 1'b0, 8'h00);
    tick();
    chk("b2b_end_busy", 32'(ifa.busy), 32'd0);

    // Reset during DATA bit 3 of 0x00
    ifa.tx_data = 8'h00; ifa.tx_valid = 1'b1;
    tick();
    ifa.tx_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_state", 32'(ifa.dbg_state), 32'd2);
    chk("mid_out",   32'(ifa.out),       32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out",   32'(ifa.out),      32'd1);
    chk("mid_rst_busy",  32'(ifa.busy),     32'd0);
    chk("mid_rst_done",  32'(ifa.done),     32'd0);
    chk("mid_rst_ready", 32'(ifa.tx_ready), 32'd0);
    tick();
    chk("mid_rst_done2", 32'(ifa.done),      32'd0);
    chk("mid_rst_state", 32'(ifa.dbg_state), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(ifa.tx_ready), 32'd1);
    ifa.tx_data = 8'h5A; ifa.tx_valid = 1'b1;
    run_frame_a("post5a", 11'b10010110100, 1'b1, 1'b0, 8'h00);

    // No-parity config, 0x00: 10-cycle frame
    exp10 = 10'b1000000000;
    done_cnt = 0;
    ifc.tx_data = 8'h00; ifc.tx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) ifc.tx_valid = 1'b0;
      if (ifc.done) done_cnt++;
      chk("c_out",  32'(ifc.out),  32'(exp10[i]));
      chk("c_done", 32'(ifc.done), 32'(i == 9));
    end
    tick();
    if (ifc.done) done_cnt++;
    chk("c_done_cnt",  32'(done_cnt),    32'd1);
    chk("c_idle_busy", 32'(ifc.busy),    32'd0);
    chk("c_idle_rdy",  32'(ifc.tx_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
